// File: rtl/scpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// scpu_ctrl_pkg
// Shared types and constants for the single-cycle CPU run/halt sequencer:
//   run_state_e  - sequencer state encoding (also driven onto the state port)
//   CAUSE_*      - halt-cause codes reported on halt_cause
//   NREG_DEF     - default number of register-file entries dumped
//   IDX_W        - width of the register select / dump index
// ----------------------------------------------------------------------------
package scpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_DUMP   = 2'd3
    } run_state_e;

    localparam logic [1:0] CAUSE_STEP  = 2'd0;
    localparam logic [1:0] CAUSE_CMD   = 2'd1;
    localparam logic [1:0] CAUSE_BRK   = 2'd2;
    localparam logic [1:0] CAUSE_LIMIT = 2'd3;

    localparam int NREG_DEF = 32;
    localparam int IDX_W    = 5;

endpackage

// File: rtl/scpu_dump_seq.sv
// ----------------------------------------------------------------------------
// scpu_dump_seq
// Walks the register file index from 0 to NREG-1 with a valid/ready handshake
// while the parent sequencer sits in its DUMP state. Only instantiated when
// SCPU_DUMP_EN is defined.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   i_active    parent is in DUMP (word presented this cycle)
//   i_abort     abort request; index returns to 0, no done pulse
//   i_ready     sink ready
//   o_valid     dump word valid
//   o_idx       index of the current dump word (also the RF read select)
//   o_last      handshake on the final word this cycle (parent leaves DUMP)
//   o_done      one-cycle pulse in the cycle after the final handshake
// ----------------------------------------------------------------------------
module scpu_dump_seq
    import scpu_ctrl_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_active,
    input  logic             i_abort,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last,
    output logic             o_done
);

    logic [IDX_W-1:0] r_idx;
    logic             r_done;
    logic             w_hs;

    // An abort in the same cycle as a handshake wins: the word is not counted.
    assign w_hs    = i_active && i_ready && !i_abort;
    assign o_last  = w_hs && (r_idx == IDX_W'(NREG - 1));
    assign o_valid = i_active;
    assign o_idx   = r_idx;
    assign o_done  = r_done;

    // Index counter and done pulse; index always parks at 0 outside a dump.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx  <= {IDX_W{1'b0}};
            r_done <= 1'b0;
        end else begin
            r_done <= o_last;
            if (i_abort || o_last) begin
                r_idx <= {IDX_W{1'b0}};
            end else if (w_hs) begin
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_idx <= r_idx;
            end
        end
    end

endmodule

// File: rtl/scpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// scpu_run_ctrl
// Run/halt sequencer for the single-cycle CPU. Gates the CPU through cpu_ce
// and supports free run, single step, a PC breakpoint and a cycle-limit stop.
// With SCPU_DUMP_EN defined, every stop is followed by a register-file dump
// through reg_sel/reg_data streamed out on dump_*; without it, stops go
// straight to HALTED and the dump outputs are tied to 0.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   cmd_run/step/halt    command pulses (priority halt > step > run)
//   brk_en, brk_pc       breakpoint enable and address
//   max_cyc              cycle limit, 0 = unlimited
//   cpu_pc               current CPU PC
//   cpu_ce               CPU clock enable
//   state, halt_cause    sequencer state and reason for the last stop
//   cyc_cnt              enabled cycles since last cmd_run (saturating)
//   reg_sel, reg_data    RF read select / data (asynchronous RF read)
//   dump_valid/ready     dump handshake
//   dump_idx, dump_data  dump word index and data
//   dump_done            one-cycle pulse after the final dump word
// ----------------------------------------------------------------------------
module scpu_run_ctrl
    import scpu_ctrl_pkg::*;
#(
    parameter int CYC_W = 16,
    parameter int NREG  = NREG_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_halt,
    input  logic             brk_en,
    input  logic [31:0]      brk_pc,
    input  logic [CYC_W-1:0] max_cyc,
    input  logic [31:0]      cpu_pc,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CYC_W-1:0] cyc_cnt,
    output logic [4:0]       reg_sel,
    input  logic [31:0]      reg_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_idx,
    output logic [31:0]      dump_data,
    output logic             dump_done
);

    run_state_e       r_state;
    run_state_e       w_state_nxt;
    run_state_e       w_stop_state;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause_nxt;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] w_cyc_inc;
    logic             r_skip;
    logic             w_skip_nxt;
    logic             w_ce;
    logic             w_cnt_clr;
    logic             w_brk_hit;
    logic             w_lim_hit;
    logic             w_dump_last;

    // skip masks the breakpoint for the first RUN cycle so a resume from the
    // breakpoint PC executes that instruction instead of re-trapping.
    assign w_brk_hit = brk_en && (cpu_pc == brk_pc) && !r_skip;
    assign w_cyc_inc = (r_cyc == {CYC_W{1'b1}}) ? r_cyc : (r_cyc + CYC_W'(1));
    assign w_lim_hit = (max_cyc != {CYC_W{1'b0}}) && (w_cyc_inc == max_cyc);

    // Next-state, clock enable and stop-cause selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_skip_nxt  = r_skip;
        w_ce        = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            ST_HALTED: begin
                if (cmd_halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (cmd_step) begin
                    w_state_nxt = ST_STEP;
                end else if (cmd_run) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_clr   = 1'b1;
                    w_skip_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_RUN: begin
                w_skip_nxt = 1'b0;
                if (cmd_halt) begin
                    w_state_nxt = w_stop_state;
                    w_cause_nxt = CAUSE_CMD;
                end else if (w_brk_hit) begin
                    // Breakpoint beats a coincident limit; the instruction is not run.
                    w_state_nxt = w_stop_state;
                    w_cause_nxt = CAUSE_BRK;
                end else if (w_lim_hit) begin
                    // The limiting cycle still executes.
                    w_ce        = 1'b1;
                    w_state_nxt = w_stop_state;
                    w_cause_nxt = CAUSE_LIMIT;
                end else begin
                    w_ce = 1'b1;
                end
            end
            ST_STEP: begin
                // cmd_halt is deliberately ignored: the step always completes.
                w_ce        = 1'b1;
                w_state_nxt = w_stop_state;
                w_cause_nxt = CAUSE_STEP;
            end
            ST_DUMP: begin
                if (cmd_halt || w_dump_last) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_state_nxt = ST_DUMP;
                end
            end
            default: begin
                w_state_nxt = ST_HALTED;
            end
        endcase
    end

    // State, cause and breakpoint-skip registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_HALTED;
            r_cause <= CAUSE_STEP;
            r_skip  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    // Executed-cycle counter: cleared by cmd_run, saturating on enabled cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cyc <= {CYC_W{1'b0}};
        end else if (w_cnt_clr) begin
            r_cyc <= {CYC_W{1'b0}};
        end else if (w_ce) begin
            r_cyc <= w_cyc_inc;
        end else begin
            r_cyc <= r_cyc;
        end
    end

    assign cpu_ce     = w_ce;
    assign state      = r_state;
    assign halt_cause = r_cause;
    assign cyc_cnt    = r_cyc;

`ifdef SCPU_DUMP_EN
    logic       w_dump_act;
    logic [4:0] w_dump_idx;

    assign w_stop_state = ST_DUMP;
    assign w_dump_act   = (r_state == ST_DUMP);

    scpu_dump_seq #(
        .NREG (NREG)
    ) u_dump_seq (
        .clk      (clk),
        .rstn     (rstn),
        .i_active (w_dump_act),
        .i_abort  (cmd_halt),
        .i_ready  (dump_ready),
        .o_valid  (dump_valid),
        .o_idx    (w_dump_idx),
        .o_last   (w_dump_last),
        .o_done   (dump_done)
    );

    assign reg_sel   = w_dump_idx;
    assign dump_idx  = w_dump_idx;
    assign dump_data = reg_data;
`else
    logic w_unused;

    assign w_stop_state = ST_HALTED;
    assign w_dump_last  = 1'b0;
    assign reg_sel      = 5'd0;
    assign dump_idx     = 5'd0;
    assign dump_data    = 32'd0;
    assign dump_valid   = 1'b0;
    assign dump_done    = 1'b0;
    assign w_unused     = (^reg_data) ^ dump_ready ^ (NREG == NREG_DEF);
`endif

endmodule

// File: tb/tb_scpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_scpu_run_ctrl
// Directed bench for scpu_run_ctrl: a table of single-cycle command vectors
// with hand-computed results, followed by multi-cycle sequences (breakpoint
// run, cycle limit, single steps, dump with back-pressure, reset mid-dump).
// A straight-line ROM is modelled as a PC that advances by 4 per enabled
// cycle; the register file holds a fixed pattern.
// ----------------------------------------------------------------------------
module tb_scpu_run_ctrl;

`ifdef SCPU_DUMP_EN
    localparam logic [1:0] ST_STOP = 2'd3;
`else
    localparam logic [1:0] ST_STOP = 2'd0;
`endif
    localparam logic [1:0] HLT = 2'd0;
    localparam logic [1:0] RUN = 2'd1;
    localparam logic [1:0] STP = 2'd2;

    logic        clk;
    logic        rstn;
    logic        cmd_run, cmd_step, cmd_halt, brk_en;
    logic [31:0] brk_pc;
    logic [15:0] max_cyc;
    logic [31:0] cpu_pc;
    logic        cpu_ce;
    logic [1:0]  state, halt_cause;
    logic [15:0] cyc_cnt;
    logic [4:0]  reg_sel, dump_idx;
    logic [31:0] reg_data, dump_data;
    logic        dump_valid, dump_ready, dump_done;
    logic [31:0] rf [32];

    int n_vec = 0;
    int n_err = 0;

    scpu_run_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_halt   (cmd_halt),
        .brk_en     (brk_en),
        .brk_pc     (brk_pc),
        .max_cyc    (max_cyc),
        .cpu_pc     (cpu_pc),
        .cpu_ce     (cpu_ce),
        .state      (state),
        .halt_cause (halt_cause),
        .cyc_cnt    (cyc_cnt),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Straight-line ROM: PC advances by 4 on every enabled cycle.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cpu_pc <= 32'd0;
        else if (cpu_ce) cpu_pc <= cpu_pc + 32'd4;
    end

    assign reg_data = rf[reg_sel];

    typedef struct {
        logic        run, step, halt, be;
        logic [31:0] bpc;
        logic [15:0] maxc;
        logic        e_ce;
        logic [1:0]  e_st, e_cause;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt [25];

    function automatic vec_t mk(input logic r, s, h, b, input logic [31:0] bp,
                                input logic [15:0] mc, input logic ce,
                                input logic [1:0] st, ca, input logic [15:0] cnt);
        vec_t v;
        v.run = r; v.step = s; v.halt = h; v.be = b; v.bpc = bp; v.maxc = mc;
        v.e_ce = ce; v.e_st = st; v.e_cause = ca; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_state"}, state, 0);
        chk({p, "_ce"}, cpu_ce, 0);
        chk({p, "_cause"}, halt_cause, 0);
        chk({p, "_cnt"}, cyc_cnt, 0);
        chk({p, "_regsel"}, reg_sel, 0);
        chk({p, "_idx"}, dump_idx, 0);
        chk({p, "_valid"}, dump_valid, 0);
        chk({p, "_done"}, dump_done, 0);
    endtask

    task automatic do_reset(input string p);
        #1 rstn = 1'b0;
        #1 chk_reset_vals(p);
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic pulse_run;
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    endtask

    task automatic to_halted(input string p);
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        chk({p, "_halted"}, state, HLT);
    endtask

    // Wait (bounded) for RUN/STEP to end, counting enabled cycles.
    task automatic wait_stop(output int ce_n);
        bit ok;
        ce_n = 0; ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (cpu_ce) ce_n++;
            if (state != RUN && state != STP) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("stop_seen", ok, 1);
    endtask

    // Drain a dump in progress, optionally toggling ready every cycle.
    task automatic run_dump(input string p, input bit toggle);
        int  exp_i, done_n;
        bit  fin, hs;
        exp_i = 0; done_n = 0; fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            dump_ready = toggle ? c[0] : 1'b1;
            #1;
            chk({p, "_valid"}, dump_valid, 1);
            chk({p, "_idx"}, dump_idx, exp_i);
            chk({p, "_regsel"}, reg_sel, exp_i);
            chk({p, "_data"}, dump_data, rf[exp_i[4:0]]);
            hs = dump_ready;
            tick();
            if (dump_done) done_n++;
            if (hs) begin
                exp_i++;
                if (exp_i == 32) fin = 1'b1;
            end
        end
        dump_ready = 1'b0;
        chk({p, "_words"}, exp_i, 32);
        chk({p, "_done_once"}, done_n, 1);
        chk({p, "_exit_state"}, state, HLT);
        tick();
        chk({p, "_done_cleared"}, dump_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce_n, step_ce;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 + (i * 32'h0101_0101);
        rstn = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
        brk_en = 1'b0; brk_pc = 32'd0; max_cyc = 16'd0; dump_ready = 1'b0;

        #2 chk_reset_vals("por");
        @(negedge clk);
        rstn = 1'b1;
        tick();

        //          run step halt be  bpc    max   ce  state    cause cnt
        vt[0]  = mk(0, 0, 0, 0, 32'h00, 16'd0, 0, HLT,     2'd0, 16'd0);
        vt[1]  = mk(0, 1, 0, 0, 32'h00, 16'd0, 0, STP,     2'd0, 16'd0);
        vt[2]  = mk(0, 0, 0, 0, 32'h00, 16'd0, 1, ST_STOP, 2'd0, 16'd1);
        vt[3]  = mk(0, 0, 1, 0, 32'h00, 16'd0, 0, HLT,     2'd0, 16'd1);
        vt[4]  = mk(1, 0, 1, 0, 32'h00, 16'd0, 0, HLT,     2'd0, 16'd1);
        vt[5]  = mk(1, 1, 0, 0, 32'h00, 16'd0, 0, STP,     2'd0, 16'd1);
        vt[6]  = mk(0, 0, 1, 0, 32'h00, 16'd0, 1, ST_STOP, 2'd0, 16'd2);
        vt[7]  = mk(0, 0, 1, 0, 32'h00, 16'd0, 0, HLT,     2'd0, 16'd2);
        vt[8]  = mk(1, 0, 0, 0, 32'h00, 16'd2, 0, RUN,     2'd0, 16'd0);
        vt[9]  = mk(0, 0, 0, 0, 32'h00, 16'd2, 1, RUN,     2'd0, 16'd1);
        vt[10] = mk(0, 0, 0, 0, 32'h00, 16'd2, 1, ST_STOP, 2'd3, 16'd2);
        vt[11] = mk(0, 0, 1, 0, 32'h00, 16'd2, 0, HLT,     2'd3, 16'd2);
        vt[12] = mk(1, 0, 0, 0, 32'h00, 16'd0, 0, RUN,     2'd3, 16'd0);
        vt[13] = mk(0, 0, 0, 0, 32'h00, 16'd0, 1, RUN,     2'd3, 16'd1);
        vt[14] = mk(0, 0, 1, 0, 32'h00, 16'd0, 0, ST_STOP, 2'd1, 16'd1);
        vt[15] = mk(0, 0, 1, 0, 32'h00, 16'd0, 0, HLT,     2'd1, 16'd1);
        vt[16] = mk(1, 0, 0, 1, 32'h14, 16'd0, 0, RUN,     2'd1, 16'd0);
        vt[17] = mk(0, 0, 0, 1, 32'h14, 16'd0, 1, RUN,     2'd1, 16'd1);
        vt[18] = mk(0, 0, 0, 1, 32'h18, 16'd0, 0, ST_STOP, 2'd2, 16'd1);
        vt[19] = mk(0, 0, 1, 0, 32'h00, 16'd0, 0, HLT,     2'd2, 16'd1);
        vt[20] = mk(1, 0, 0, 1, 32'h20, 16'd3, 0, RUN,     2'd2, 16'd0);
        vt[21] = mk(0, 0, 0, 1, 32'h20, 16'd3, 1, RUN,     2'd2, 16'd1);
        vt[22] = mk(0, 0, 0, 1, 32'h20, 16'd3, 1, RUN,     2'd2, 16'd2);
        vt[23] = mk(0, 0, 0, 1, 32'h20, 16'd3, 0, ST_STOP, 2'd2, 16'd2);
        vt[24] = mk(0, 0, 1, 0, 32'h00, 16'd0, 0, HLT,     2'd2, 16'd2);

        for (int i = 0; i < 25; i++) begin
            cmd_run = vt[i].run; cmd_step = vt[i].step; cmd_halt = vt[i].halt;
            brk_en = vt[i].be; brk_pc = vt[i].bpc; max_cyc = vt[i].maxc;
            #1;
            chk($sformatf("v%0d_ce", i), cpu_ce, vt[i].e_ce);
            tick();
            chk($sformatf("v%0d_state", i), state, vt[i].e_st);
            chk($sformatf("v%0d_cause", i), halt_cause, vt[i].e_cause);
            chk($sformatf("v%0d_cnt", i), cyc_cnt, vt[i].e_cnt);
        end
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
        chk("table_pc", cpu_pc, 32'h20);

        // Breakpoint at 0x48 from PC 0: 18 instructions run, 0x48 does not.
        do_reset("rst1");
        brk_en = 1'b1; brk_pc = 32'h48; max_cyc = 16'd0;
        pulse_run();
        wait_stop(ce_n);
        chk("brk_ce_cycles", ce_n, 18);
        chk("brk_pc", cpu_pc, 32'h48);
        chk("brk_cnt", cyc_cnt, 18);
        chk("brk_cause", halt_cause, 2);
        chk("brk_state", state, ST_STOP);
`ifdef SCPU_DUMP_EN
        run_dump("dump1", 1'b0);
`else
        chk("nodump_valid", dump_valid, 0);
        chk("nodump_regsel", reg_sel, 0);
        chk("nodump_data", dump_data, 0);
`endif

        // Resume from the breakpoint PC: the trapped instruction now executes.
        pulse_run();
        #1 chk("resume_ce", cpu_ce, 1);
        tick();
        chk("resume_pc", cpu_pc, 32'h4C);
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        chk("resume_cause", halt_cause, 1);
        chk("resume_state", state, ST_STOP);
        to_halted("resume");

        // Cycle limit of 5.
        brk_en = 1'b0; max_cyc = 16'd5;
        pulse_run();
        wait_stop(ce_n);
        chk("lim_ce_cycles", ce_n, 5);
        chk("lim_cnt", cyc_cnt, 5);
        chk("lim_cause", halt_cause, 3);
        chk("lim_pc", cpu_pc, 32'h60);
        to_halted("lim");

        // Three spaced single steps after reset.
        do_reset("rst3");
        max_cyc = 16'd0;
        for (int k = 0; k < 3; k++) begin
            cmd_step = 1'b1; tick(); cmd_step = 1'b0;
            step_ce = 0;
            for (int j = 0; j < 4; j++) begin
                #1 if (cpu_ce) step_ce++;
                tick();
            end
            chk($sformatf("step%0d_ce", k), step_ce, 1);
            to_halted($sformatf("step%0d", k));
        end
        chk("step_cnt", cyc_cnt, 3);
        chk("step_pc", cpu_pc, 32'h0C);
        chk("step_cause", halt_cause, 0);

`ifdef SCPU_DUMP_EN
        // Dump with ready toggling every cycle.
        cmd_step = 1'b1; tick(); cmd_step = 1'b0;
        tick();
        chk("dump2_entry", state, 3);
        run_dump("dump2", 1'b1);

        // Asynchronous reset while the dump sits at index 10.
        cmd_step = 1'b1; tick(); cmd_step = 1'b0;
        tick();
        dump_ready = 1'b1;
        for (int c = 0; c < 40 && dump_idx != 5'd10; c++) tick();
        dump_ready = 1'b0;
        #1 chk("mid_idx", dump_idx, 10);
        #1 rstn = 1'b0;
        #1 chk_reset_vals("mid_rst");
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("post_rst_state", state, HLT);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
